// File: rtl/rtc_bus_scheduler_pkg.sv
// Shared types and constants for the RTC bus scheduler.
// Holds the state encoding, the burst read table and parameter defaults.
package rtc_bus_scheduler_pkg;

    localparam int T_PULSE_DEF        = 10;
    localparam int REFRESH_PERIOD_DEF = 1000000;
    localparam int N_RD               = 7;
    localparam int IDX_W              = $clog2(N_RD);

    // Entry 0 is read first.
    localparam logic [N_RD-1:0][7:0] RD_SEQ = {
        8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };

    typedef enum logic [2:0] {
        IDLE,
        ADDR_LOW,
        ADDR_HIGH,
        DATA_LOW,
        RECOVER
    } state_t;

    typedef struct packed {
        logic       is_read;
        logic [7:0] addr;
        logic [7:0] data;
    } xact_t;

endpackage

// File: rtl/rtc_phase_timer.sv
// Bus phase timer: loads T_PULSE-1, counts down and pulses done
// on the last cycle of the phase.
module rtc_phase_timer
    import rtc_bus_scheduler_pkg::*;
#(
    parameter int T_PULSE = T_PULSE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int CW = (T_PULSE > 1) ? $clog2(T_PULSE) : 1;

    logic [CW-1:0] cnt;
    logic          run;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (load) begin
            cnt <= CW'(T_PULSE - 1);
            run <= 1'b1;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end else begin
            run <= 1'b0;
        end
    end

    assign done = run && (cnt == '0);

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Multiplexed RTC bus scheduler: arbitrates configuration writes
// against periodic read bursts and sequences the a_d/cs/rd/wr strobes.
module rtc_bus_scheduler
    import rtc_bus_scheduler_pkg::*;
#(
    parameter int T_PULSE        = T_PULSE_DEF,
    parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_req,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       wr_ack,
    input  logic       rd_burst_en,
    output logic       rd_valid,
    output logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [7:0] dato_out,
    output logic       dato_oe,
    input  logic [7:0] dato_in,
    output logic       busy
);

    localparam int RW = $clog2(REFRESH_PERIOD + 1);

    state_t           state;
    state_t           state_nxt;
    xact_t            cur;
    logic             phase_done;
    logic             tmr_load;
    logic             start;
    logic             wrap;
    logic             xact_end;
    logic [RW-1:0]    refresh_cnt;
    logic             burst_pending;
    logic [IDX_W-1:0] burst_idx;

    assign start    = wr_req || (burst_pending && rd_burst_en);
    assign wrap     = (refresh_cnt == RW'(REFRESH_PERIOD - 1));
    assign xact_end = (state == RECOVER) && phase_done;
    assign tmr_load = (state_nxt != state) && (state_nxt != IDLE);

    rtc_phase_timer #(
        .T_PULSE(T_PULSE)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (tmr_load),
        .done (phase_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (start)      state_nxt = ADDR_LOW;
            ADDR_LOW:  if (phase_done) state_nxt = ADDR_HIGH;
            ADDR_HIGH: if (phase_done) state_nxt = DATA_LOW;
            DATA_LOW:  if (phase_done) state_nxt = RECOVER;
            RECOVER:   if (phase_done) state_nxt = IDLE;
            default:                   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        a_d      = 1'b1;
        cs       = 1'b1;
        rd       = 1'b1;
        wr       = 1'b1;
        dato_oe  = 1'b0;
        dato_out = 8'h00;
        unique case (state)
            ADDR_LOW: begin
                a_d      = 1'b0;
                cs       = 1'b0;
                wr       = 1'b0;
                dato_oe  = 1'b1;
                dato_out = cur.addr;
            end
            DATA_LOW: begin
                cs = 1'b0;
                if (cur.is_read) begin
                    rd = 1'b0;
                end else begin
                    wr       = 1'b0;
                    dato_oe  = 1'b1;
                    dato_out = cur.data;
                end
            end
            default: ;
        endcase
    end

    assign busy   = (state != IDLE);
    assign wr_ack = xact_end && !cur.is_read;

    // Writes win arbitration; the burst index only moves when a read retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur <= '0;
        end else if (state == IDLE && start) begin
            if (wr_req) cur <= '{is_read: 1'b0, addr: wr_addr, data: wr_data};
            else        cur <= '{is_read: 1'b1, addr: RD_SEQ[burst_idx], data: 8'h00};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
        end else if (wrap) begin
            refresh_cnt <= '0;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            burst_pending <= 1'b0;
            burst_idx     <= '0;
        end else if (xact_end && cur.is_read) begin
            if (!rd_burst_en || burst_idx == IDX_W'(N_RD - 1)) begin
                burst_pending <= 1'b0;
                burst_idx     <= '0;
            end else begin
                burst_idx <= burst_idx + 1'b1;
            end
        end else if (state == IDLE && burst_pending && !rd_burst_en) begin
            burst_pending <= 1'b0;
            burst_idx     <= '0;
        end else if (wrap && rd_burst_en && !burst_pending) begin
            burst_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_addr  <= 8'h00;
            rd_data  <= 8'h00;
        end else if (state == DATA_LOW && phase_done && cur.is_read) begin
            rd_valid <= 1'b1;
            rd_addr  <= cur.addr;
            rd_data  <= dato_in;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule
